// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: bit-clock generator, 3rd-order CIC decimate-by-64 to 16-bit PCM, show-ahead FIFO.
// Optional one-pole DC-removal stage after saturation is built when PDM_DC_BLOCK_EN is defined.
module pdm_cic_decimator #(
    parameter int CLK_HALF   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_100MHz,
    input  logic                          sysreset_n,
    input  logic                          enable,
    input  logic                          pdm_data,
    output logic                          pdm_clk,
    output logic [15:0]                   pcm_data,
    output logic                          pcm_valid,
    input  logic                          pcm_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [7:0] DIV_TC = 8'(CLK_HALF - 1);

    logic [7:0]    div_q, div_d;
    logic          pdm_clk_q, pdm_clk_d;
    logic          rise;
    logic [5:0]    dec_q, dec_d;
    logic [19:0]   int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
    logic [19:0]   cap_q, cap_d;
    logic [19:0]   comb1_q, comb1_d, comb2_q, comb2_d, comb3_q, comb3_d;
    logic [19:0]   dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
    logic [3:0]    vld_q, vld_d;
    logic [15:0]   sat_out;
    logic          push;
    logic [15:0]   push_data;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, wr_en;

    function automatic logic [15:0] sat16(input logic signed [19:0] v);
        if (v > 20'sd32767)       sat16 = 16'h7FFF;
        else if (v < -20'sd32768) sat16 = 16'h8000;
        else                      sat16 = v[15:0];
    endfunction

    // vld_q[0] marks a captured decimated sample, vld_q[1..3] the comb stages.
    always_comb begin
        div_d     = div_q;
        pdm_clk_d = pdm_clk_q;
        rise      = 1'b0;
        dec_d     = dec_q;
        int1_d    = int1_q;
        int2_d    = int2_q;
        int3_d    = int3_q;
        cap_d     = cap_q;
        comb1_d   = comb1_q;
        comb2_d   = comb2_q;
        comb3_d   = comb3_q;
        dly1_d    = dly1_q;
        dly2_d    = dly2_q;
        dly3_d    = dly3_q;
        vld_d     = '0;
        if (!enable) begin
            div_d     = '0;
            pdm_clk_d = 1'b0;
            dec_d     = '0;
            int1_d    = '0;
            int2_d    = '0;
            int3_d    = '0;
            cap_d     = '0;
            comb1_d   = '0;
            comb2_d   = '0;
            comb3_d   = '0;
            dly1_d    = '0;
            dly2_d    = '0;
            dly3_d    = '0;
        end else begin
            if (div_q == DIV_TC) begin
                div_d     = '0;
                pdm_clk_d = ~pdm_clk_q;
                rise      = ~pdm_clk_q;
            end else begin
                div_d = div_q + 8'd1;
            end
            if (rise) begin
                int1_d = int1_q + (pdm_data ? 20'd1 : 20'hFFFFF);
                int2_d = int2_q + int1_q;
                int3_d = int3_q + int2_q;
                dec_d  = dec_q + 6'd1;
            end
            if (rise && dec_q == 6'd63) begin
                cap_d    = int3_d;
                vld_d[0] = 1'b1;
            end
            if (vld_q[0]) begin
                comb1_d  = cap_q - dly1_q;
                dly1_d   = cap_q;
                vld_d[1] = 1'b1;
            end
            if (vld_q[1]) begin
                comb2_d  = comb1_q - dly2_q;
                dly2_d   = comb1_q;
                vld_d[2] = 1'b1;
            end
            if (vld_q[2]) begin
                comb3_d  = comb2_q - dly3_q;
                dly3_d   = comb2_q;
                vld_d[3] = 1'b1;
            end
        end
    end

    assign sat_out = sat16($signed(comb3_q) >>> 3);

`ifdef PDM_DC_BLOCK_EN
    logic [15:0]        dcx_q, dcx_d;
    logic [17:0]        dcy_q, dcy_d;
    logic               dcv_q, dcv_d;
    logic signed [19:0] dc_acc;

    always_comb begin
        dc_acc = $signed({{4{sat_out[15]}}, sat_out}) - $signed({{4{dcx_q[15]}}, dcx_q})
               + $signed({{2{dcy_q[17]}}, dcy_q}) - ($signed({{2{dcy_q[17]}}, dcy_q}) >>> 8);
        dcx_d  = dcx_q;
        dcy_d  = dcy_q;
        dcv_d  = 1'b0;
        if (!enable) begin
            dcx_d = '0;
            dcy_d = '0;
        end else if (vld_q[3]) begin
            dcx_d = sat_out;
            dcv_d = 1'b1;
            if (dc_acc > 20'sd131071)       dcy_d = 18'h1FFFF;
            else if (dc_acc < -20'sd131072) dcy_d = 18'h20000;
            else                            dcy_d = dc_acc[17:0];
        end
    end

    always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
        if (!sysreset_n) begin
            dcx_q <= '0;
            dcy_q <= '0;
            dcv_q <= 1'b0;
        end else begin
            dcx_q <= dcx_d;
            dcy_q <= dcy_d;
            dcv_q <= dcv_d;
        end
    end

    assign push      = dcv_q;
    assign push_data = sat16($signed({{2{dcy_q[17]}}, dcy_q}));
`else
    assign push      = vld_q[3];
    assign push_data = sat_out;
`endif

    // A push into a full FIFO still lands if the head is popped in the same cycle.
    always_comb begin
        full  = (cnt_q == LW'(FIFO_DEPTH));
        pop   = (cnt_q != '0) && pcm_ready;
        wr_en = push && (!full || pop);
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~ovf_clr;
        if (wr_en) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PW'(1);
        end
        if (push && full && !pop) ovf_d = 1'b1;
        if (pop) rd_d = rd_q + PW'(1);
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
        if (!sysreset_n) begin
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
            dec_q     <= '0;
            int1_q    <= '0;
            int2_q    <= '0;
            int3_q    <= '0;
            cap_q     <= '0;
            comb1_q   <= '0;
            comb2_q   <= '0;
            comb3_q   <= '0;
            dly1_q    <= '0;
            dly2_q    <= '0;
            dly3_q    <= '0;
            vld_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
            dec_q     <= dec_d;
            int1_q    <= int1_d;
            int2_q    <= int2_d;
            int3_q    <= int3_d;
            cap_q     <= cap_d;
            comb1_q   <= comb1_d;
            comb2_q   <= comb2_d;
            comb3_q   <= comb3_d;
            dly1_q    <= dly1_d;
            dly2_q    <= dly2_d;
            dly3_q    <= dly3_d;
            vld_q     <= vld_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pdm_clk    = pdm_clk_q;
    assign pcm_valid  = (cnt_q != '0);
    assign pcm_data   = pcm_valid ? mem_q[rd_q] : '0;
    assign fifo_level = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator: vector table of PDM patterns plus hand sequences
// for FIFO overflow, enable gating and async reset; popped samples checked against a scoreboard.
module tb_pdm_cic_decimator;
    localparam int CLK_HALF   = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int SAMPLE_CYC = 64 * 2 * CLK_HALF;

    logic        clk_100MHz = 1'b0;
    logic        sysreset_n;
    logic        enable;
    logic        pdm_data;
    logic        pdm_clk;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        ovf_clr;

    pdm_cic_decimator #(.CLK_HALF(CLK_HALF), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_100MHz (clk_100MHz),
        .sysreset_n (sysreset_n),
        .enable     (enable),
        .pdm_data   (pdm_data),
        .pdm_clk    (pdm_clk),
        .pcm_data   (pcm_data),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // 0: constant 0, 1: constant 1, 2: toggle on every pdm_clk fall
    int   mode = 0;
    logic prev_pclk;
    always @(posedge clk_100MHz) begin
        #1;
        if (mode == 0)      pdm_data = 1'b0;
        else if (mode == 1) pdm_data = 1'b1;
        else if (prev_pclk && !pdm_clk) pdm_data = ~pdm_data;
        prev_pclk = pdm_clk;
    end

    typedef struct { int val; bit chk; } sb_t;
    typedef struct { int mode; int nsamp; int steady; } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[3];
    int   total = 0;
    int   bad = 0;
    int   last_pop = 0;
    int   gap = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void expect_sample(input int val, input bit chk);
        sb_t e;
        e.val = val;
        e.chk = chk;
        sb_q.push_back(e);
    endfunction

    task automatic pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop actual=%0d required=none", $signed(pcm_data));
        end else begin
            e = sb_q.pop_front();
            if (e.chk) check("pcm_sample", int'($signed(pcm_data)), e.val);
            gap      = cyc - last_pop;
            last_pop = cyc;
        end
    endtask

    // One clock: observe handshake at negedge, return at posedge+2 for driving.
    task automatic tick();
        @(negedge clk_100MHz);
        if (sysreset_n && pcm_valid && pcm_ready) pop_check();
        @(posedge clk_100MHz);
        #2;
    endtask

    task automatic wait_level(input int lvl, input int budget);
        int n = 0;
        while (int'(fifo_level) != lvl && n < budget) begin
            tick();
            n++;
        end
        check("level_reached", int'(fifo_level), lvl);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pdm_clk"},    int'(pdm_clk),    0);
        check({tag, "_pcm_data"},   int'(pcm_data),   0);
        check({tag, "_pcm_valid"},  int'(pcm_valid),  0);
        check({tag, "_fifo_level"}, int'(fifo_level), 0);
        check({tag, "_overflow"},   int'(overflow),   0);
    endtask

    initial begin
        int n;
        int w5;
        vecs[0] = '{mode: 1, nsamp: 4, steady: 32767};
        vecs[1] = '{mode: 0, nsamp: 4, steady: -32768};
        vecs[2] = '{mode: 2, nsamp: 4, steady: 0};

        sysreset_n = 1'b0;
        enable     = 1'b0;
        pcm_ready  = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        #2;
        check_all_zero("reset");
        sysreset_n = 1'b1;
        repeat (3) tick();

        for (int v = 0; v < 3; v++) begin
            mode      = vecs[v].mode;
            pcm_ready = 1'b1;
            for (int s = 0; s < vecs[v].nsamp; s++) expect_sample(vecs[v].steady, s >= 2);
            enable = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
            end while (!pdm_clk && n < 100);
            check("first_rise", n, CLK_HALF);
            n = 0;
            while (pdm_clk && n < 100) begin tick(); n++; end
            check("high_time", n, CLK_HALF);
            n = 0;
            while (!pdm_clk && n < 100) begin tick(); n++; end
            check("low_time", n, CLK_HALF);
            wait_drain(vecs[v].nsamp * SAMPLE_CYC + 3000);
            check("sample_gap", gap, SAMPLE_CYC);
            enable = 1'b0;
            repeat (4) tick();
        end

        // enable dropped mid-decimation: no partial sample, FIFO kept
        mode      = 1;
        pcm_ready = 1'b0;
        enable    = 1'b1;
        expect_sample(0, 1'b0);
        wait_level(1, SAMPLE_CYC + 300);
        repeat (1000) tick();
        enable = 1'b0;
        tick();
        check("pdm_clk_low_disabled", int'(pdm_clk), 0);
        n = 0;
        repeat (2500) begin
            tick();
            if (pdm_clk) n++;
        end
        check("pdm_clk_high_count_disabled", n, 0);
        check("no_partial_write", int'(fifo_level), 1);
        enable = 1'b1;
        expect_sample(0, 1'b0);
        expect_sample(0, 1'b0);
        expect_sample(32767, 1'b1);
        wait_level(4, 3 * SAMPLE_CYC + 300);
        enable    = 1'b0;
        pcm_ready = 1'b1;
        wait_drain(50);
        pcm_ready = 1'b0;
        tick();

        // overflow, ovf_clr, simultaneous push/pop while full
        mode   = 1;
        enable = 1'b1;
        expect_sample(0, 1'b0);
        expect_sample(0, 1'b0);
        expect_sample(32767, 1'b1);
        expect_sample(32767, 1'b1);
        n = 0;
        while (!overflow && n < 5 * SAMPLE_CYC + 300) begin tick(); n++; end
        w5 = cyc;
        check("overflow_set", int'(overflow), 1);
        check("full_level", int'(fifo_level), FIFO_DEPTH);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("overflow_cleared", int'(overflow), 0);
        while (cyc < w5 + SAMPLE_CYC - 1) tick();
        pcm_ready = 1'b1;
        expect_sample(32767, 1'b1);
        tick();
        pcm_ready = 1'b0;
        check("push_pop_full_level", int'(fifo_level), FIFO_DEPTH);
        check("push_pop_full_ovf", int'(overflow), 0);
        while (cyc < w5 + 2 * SAMPLE_CYC - 1) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_set_beats_clr", int'(overflow), 1);
        check("still_full", int'(fifo_level), FIFO_DEPTH);
        enable    = 1'b0;
        pcm_ready = 1'b1;
        wait_drain(50);
        pcm_ready = 1'b0;
        tick();
        check("empty_after_drain", int'(fifo_level), 0);

        // async reset mid-stream, overflow still set from above
        enable = 1'b1;
        wait_level(1, SAMPLE_CYC + 300);
        check("overflow_before_reset", int'(overflow), 1);
        #2;
        sysreset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb_q.delete();
        enable = 1'b0;
        repeat (2) @(posedge clk_100MHz);
        #2;
        sysreset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

PDM microphone front end: generates the on-board microphone bit clock, samples the already-synchronized PDM stream, and decimates it by 64 with a 3rd-order CIC filter into 16-bit signed PCM. Samples are buffered in a small FIFO and handed to the embedded system (AXI-stream/GPIO wrapper) over a valid/ready interface. Sits directly downstream of the top-level micData 3-stage synchronizer and replaces the BUFR/BUFG micClk path.

## Interface

Parameters:
- CLK_HALF, 16, clk_100MHz cycles per pdm_clk half-period (pdm_clk = 100 MHz / (2*CLK_HALF) = 3.125 MHz); legal range 4..255
- FIFO_DEPTH, 4, PCM FIFO entries; power of two, 2..16

Ports:
- clk_100MHz  input  1  system clock; the only clock
- sysreset_n  input  1  asynchronous, active-low reset
- enable  input  1  run when high
- pdm_data  input  1  synchronized PDM bit from the microphone
- pdm_clk  output  1  microphone bit clock (registered)
- pcm_data  output  16  signed PCM sample, FIFO head
- pcm_valid  output  1  FIFO non-empty
- pcm_ready  input  1  consumer accepts head when high with pcm_valid
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky: a sample was dropped
- ovf_clr  input  1  one-cycle pulse clears overflow

## Operation

- Reset values: pdm_clk=0, pcm_data=0, pcm_valid=0, fifo_level=0, overflow=0; divider, decimation counter, integrators, combs, FIFO pointers all 0.
- Clock divider: counter 0..CLK_HALF-1; at terminal count pdm_clk toggles and counter returns to 0. rise strobe = cycle in which pdm_clk is registered 0→1.
- Sampling: on rise strobe, pdm_data is mapped 1→+1, 0→-1 (20-bit two's complement) and fed to three cascaded integrators, 20-bit, wrap-around arithmetic (overflow intended).
- Decimation counter 0..63 increments on rise strobe; on the strobe where it equals 63 the final integrator value is captured for the comb pipeline.
- Combs: three stages, differential delay 1, 20-bit wrap-around, one stage per clock cycle. Output range [-262144, +262144].
- Scaling: pcm = saturate16(comb_out >>> 3) — +32768 saturates to 32767; minimum -32768.
- FIFO: show-ahead; pcm_data/pcm_valid reflect head. Pop when pcm_valid && pcm_ready.
- Push while full: sample discarded, overflow set. Push and pop in same cycle while full: both occur, no overflow. Push while empty: pcm_valid rises the next cycle (no bypass).
- ovf_clr and a new overflow event in the same cycle: overflow remains 1.
- enable low: pdm_clk driven 0 and divider held at 0; integrators, combs, decimation counter and any in-flight comb sample cleared; FIFO contents, overflow and handshake unaffected. enable high resumes with divider at 0.
- Async reset mid-operation clears everything immediately, including FIFO contents.

## Timing

- pdm_clk period = 2*CLK_HALF cycles (32 at default); first rise CLK_HALF cycles after enable goes high.
- Decimation output rate = pdm_clk / 64 (48.83 kHz default), one sample per 64*2*CLK_HALF = 2048 cycles.
- Latency from decimating rise strobe to FIFO write: 4 cycles (3 comb + 1 saturate); pcm_valid high on the cycle after write. With PDM_DC_BLOCK_EN: 5 cycles.
- CIC settling: first 2 output samples after reset/enable are transient; from the 3rd onward a constant input yields its steady-state value.
- Consumer may hold pcm_ready high indefinitely; throughput 1 sample/cycle from FIFO.

## Configuration

- PDM_DC_BLOCK_EN defined: a single-pole DC-removal stage follows saturation: y[n] = x[n] − x[n−1] + y[n−1] − (y[n−1] >>> 8), 18-bit signed internal, result saturated to 16 bits; state cleared by reset and by enable low; adds 1 cycle latency.
- Not defined: saturated CIC output written to FIFO directly; no DC-removal logic synthesized.

## Test plan

- Reset, enable=1, observe pdm_clk → period 32 cycles, 50% duty, first rise 16 cycles after enable; one FIFO write every 2048 cycles.
- pdm_data constant 1, pcm_ready=1, no macro → from 3rd sample onward pcm_data = 32767; constant 0 → -32768.
- pdm_data alternating 1,0 per pdm_clk → steady-state pcm_data = 0; with PDM_DC_BLOCK_EN, constant 1 input decays toward 0 (below 1000 within 2000 samples).
- pcm_ready=0 for 5 output samples, FIFO_DEPTH=4 → fifo_level=4, 5th sample dropped, overflow=1; pop then ovf_clr → overflow=0, first 4 samples read in order.
- FIFO full, pop and push same cycle → fifo_level stays 4, overflow stays 0.
- enable deasserted mid-decimation then reasserted → pdm_clk low while disabled, FIFO contents preserved, no partial sample written; async reset mid-stream → all outputs 0 immediately.
